// File: rtl/div_tick_pkg.sv
// Purpose: shared types and constants for the divide-by-N tick generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_tick_pkg;

  // Pending-configuration state: IDLE accepts a new config, PEND holds one
  // in the shadow registers until the counter reaches a safe apply point.
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } cfg_state_e;

  // Smallest divide ratio minus one that still yields a meaningful tick.
  localparam int unsigned MIN_DIV_M1 = 1;

endpackage

// File: rtl/div_tick_cnt.sv
// Purpose: free-running divide counter with wrap detect and synchronous apply-clear.
// Latency: counter updates on each rising edge; o_wrap is combinational from current count.
// Backpressure: none; i_en low freezes the count.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   i_en         count enable
//   i_apply      clear the counter to 0 on this edge (new config takes effect)
//   i_div_m1     active divide ratio minus one (wrap point)
//   o_cnt        current counter value
//   o_wrap       counter sits on its wrap value with enable high
module div_tick_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_apply,
  input  logic [CNT_W-1:0] i_div_m1,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_wrap
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_wrap;

  assign w_wrap = i_en && (r_cnt == i_div_m1);

  // Apply wins over everything, including a held (en=0) counter.
  // The increment cannot overflow: the wrap point is at most 2^CNT_W-1.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_apply) begin
      w_cnt_nxt = '0;
    end else if (w_wrap) begin
      w_cnt_nxt = '0;
    end else if (i_en) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_wrap = w_wrap;

endmodule

// File: rtl/div_tick_gen.sv
// Purpose: programmable divide-by-N tick generator with a one-deep shadowed config port.
// Latency: po_flag rises one cycle after the edge that samples cnt==phase; configs apply at the next wrap.
// Backpressure: cfg_rdy drops while a config is pending; cfg_vld offered while cfg_rdy=0 is ignored.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   en                      count enable (counter and po_sq hold when low)
//   cfg_vld / cfg_rdy       configuration handshake
//   cfg_div_m1, cfg_phase   requested ratio minus one and pulse phase
//   po_flag                 registered one-cycle tick per divide period
//   po_sq                   registered square wave (only with DIV_TICK_SQUARE_EN defined)
//   cnt_o                   current counter value
// Optional feature macro: DIV_TICK_SQUARE_EN adds the po_sq output.
module div_tick_gen
  import div_tick_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int RST_DIV_M1 = 3,
  parameter int RST_PHASE  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_vld,
  input  logic [CNT_W-1:0] cfg_div_m1,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic             cfg_rdy,
  output logic             po_flag,
`ifdef DIV_TICK_SQUARE_EN
  output logic             po_sq,
`endif
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] RST_DIV_M1_V = CNT_W'(RST_DIV_M1);
  localparam logic [CNT_W-1:0] RST_PHASE_V  = CNT_W'(RST_PHASE);
  localparam logic [CNT_W-1:0] MIN_DIV_M1_V = CNT_W'(MIN_DIV_M1);

  cfg_state_e       r_state;
  cfg_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_div_m1;
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] r_shd_div_m1;
  logic [CNT_W-1:0] r_shd_phase;
  logic             r_flag;
  logic [CNT_W-1:0] w_cnt;
  logic             w_wrap;
  logic             w_accept;
  logic             w_apply;
  logic             w_cfg_rdy;
  logic [CNT_W-1:0] w_cap_div_m1;
  logic [CNT_W-1:0] w_cap_phase;

  div_tick_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (en),
    .i_apply  (w_apply),
    .i_div_m1 (r_div_m1),
    .o_cnt    (w_cnt),
    .o_wrap   (w_wrap)
  );

  // Clamp at capture so the active registers always hold a legal pair:
  // div_m1 >= 1 and phase <= div_m1 (a phase past the wrap would never fire).
  always_comb begin
    w_cap_div_m1 = (cfg_div_m1 == '0) ? MIN_DIV_M1_V : cfg_div_m1;
    w_cap_phase  = (cfg_phase > w_cap_div_m1) ? w_cap_div_m1 : cfg_phase;
  end

  assign w_accept = cfg_vld && w_cfg_rdy;

  // ---- pending-config FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- pending-config FSM: next state ----
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = PEND;
      PEND:    if (w_apply)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---- pending-config FSM: outputs ----
  // A stalled counter would never reach its wrap, so a pending config is
  // applied on the next edge whenever en is low.
  always_comb begin
    w_cfg_rdy = 1'b0;
    w_apply   = 1'b0;
    unique case (r_state)
      IDLE:    w_cfg_rdy = 1'b1;
      PEND:    w_apply   = w_wrap || !en;
      default: w_cfg_rdy = 1'b0;
    endcase
  end

  // Shadow capture and active-config load. Accept only happens in IDLE and
  // apply only in PEND, so a config accepted on a wrap edge waits a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shd_div_m1 <= RST_DIV_M1_V;
      r_shd_phase  <= RST_PHASE_V;
      r_div_m1     <= RST_DIV_M1_V;
      r_phase      <= RST_PHASE_V;
    end else begin
      if (w_accept) begin
        r_shd_div_m1 <= w_cap_div_m1;
        r_shd_phase  <= w_cap_phase;
      end
      if (w_apply) begin
        r_div_m1 <= r_shd_div_m1;
        r_phase  <= r_shd_phase;
      end
    end
  end

  // The tick compares against the config active at the sampling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag <= 1'b0;
    end else begin
      r_flag <= en && (w_cnt == r_phase);
    end
  end

`ifdef DIV_TICK_SQUARE_EN
  logic             r_sq;
  logic [CNT_W-1:0] w_sq_cnt_nxt;
  logic [CNT_W-1:0] w_sq_div_nxt;

  // Square wave is a function of the post-edge count and ratio, so it is
  // registered in step with the counter. With en low and no apply both
  // inputs are unchanged, which makes po_sq hold.
  always_comb begin
    w_sq_div_nxt = w_apply ? r_shd_div_m1 : r_div_m1;
    w_sq_cnt_nxt = w_cnt;
    if (w_apply || w_wrap) begin
      w_sq_cnt_nxt = '0;
    end else if (en) begin
      w_sq_cnt_nxt = w_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sq <= 1'b1;
    end else begin
      r_sq <= (w_sq_cnt_nxt <= (w_sq_div_nxt >> 1));
    end
  end

  assign po_sq = r_sq;
`endif

  assign cfg_rdy = w_cfg_rdy;
  assign po_flag = r_flag;
  assign cnt_o   = w_cnt;

endmodule

// File: tb/tb_div_tick_gen.sv
// Purpose: self-checking bench for div_tick_gen against a cycle-level behavioural model.
// Latency: model is advanced at each rising edge; outputs compared on the falling edge.
// Backpressure: the model tracks cfg_rdy from its own pending flag.
module tb_div_tick_gen;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         cfg_vld;
  logic [W-1:0] cfg_div_m1;
  logic [W-1:0] cfg_phase;
  logic         cfg_rdy;
  logic         po_flag;
  logic [W-1:0] cnt_o;
`ifdef DIV_TICK_SQUARE_EN
  logic         po_sq;
`endif

  div_tick_gen #(
    .CNT_W      (W),
    .RST_DIV_M1 (3),
    .RST_PHASE  (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cfg_vld    (cfg_vld),
    .cfg_div_m1 (cfg_div_m1),
    .cfg_phase  (cfg_phase),
    .cfg_rdy    (cfg_rdy),
    .po_flag    (po_flag),
`ifdef DIV_TICK_SQUARE_EN
    .po_sq      (po_sq),
`endif
    .cnt_o      (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: position within the period, active and shadow config.
  int unsigned m_cnt, m_div, m_phase, s_div, s_phase;
  bit          m_pend, m_flag, m_sq;

  task automatic model_reset();
    m_cnt = 0; m_div = 3; m_phase = 2; s_div = 3; s_phase = 2;
    m_pend = 0; m_flag = 0; m_sq = 1;
  endtask

  // One rising edge, given the inputs that were stable across it.
  task automatic model_edge(input bit e, input bit v, input int unsigned d, input int unsigned p);
    bit accept;
    int unsigned dc;
    accept = v && !m_pend;
    m_flag = e && (m_cnt == m_phase);
    if (m_pend && (!e || m_cnt == m_div)) begin
      m_cnt = 0; m_div = s_div; m_phase = s_phase; m_pend = 0;
    end else if (e) begin
      m_cnt = (m_cnt + 1) % (m_div + 1);
    end
    if (accept) begin
      dc = (d == 0) ? 1 : d;
      s_div = dc;
      s_phase = (p > dc) ? dc : p;
      m_pend = 1;
    end
    m_sq = (m_cnt <= m_div / 2);
  endtask

  // Inputs change on the falling edge; model follows the rising edge.
  task automatic step(input bit e, input bit v, input int unsigned d, input int unsigned p);
    en = e; cfg_vld = v; cfg_div_m1 = W'(d); cfg_phase = W'(p);
    @(posedge clk);
    model_edge(e, v, d, p);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cnt_o", cnt_o, m_cnt);
      chk("po_flag", po_flag, m_flag);
      chk("cfg_rdy", cfg_rdy, !m_pend);
`ifdef DIV_TICK_SQUARE_EN
      chk("po_sq", po_sq, m_sq);
`endif
    end
  end

  initial begin
    rst_n = 1'b1; en = 1'b0; cfg_vld = 1'b0; cfg_div_m1 = '0; cfg_phase = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cnt", cnt_o, 0);
    chk("rst_rdy", cfg_rdy, 1);
    chk("rst_flag", po_flag, 0);
`ifdef DIV_TICK_SQUARE_EN
    chk("rst_sq", po_sq, 1);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Default divide-by-4, phase 2: ticks on cycles 3, 7, 11.
    for (int k = 1; k <= 12; k++) begin
      step(1, 0, 0, 0);
      chk("div4_cnt", cnt_o, k % 4);
      chk("div4_flag", po_flag, (k % 4 == 3) ? 1 : 0);
    end

    // Hold at cnt=2 for five cycles, then resume: tick one cycle later.
    run(2);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0);
      chk("hold_cnt", cnt_o, 2);
      chk("hold_flag", po_flag, 0);
    end
    step(1, 0, 0, 0);
    chk("resume_cnt", cnt_o, 3);
    chk("resume_flag", po_flag, 1);
    step(1, 0, 0, 0);
    chk("resume_wrap", cnt_o, 0);

    // Mid-period config div 9 / phase 5: waits for the wrap, then period 10.
    step(1, 0, 0, 0);
    step(1, 1, 9, 5);
    chk("pend_rdy", cfg_rdy, 0);
    chk("pend_cnt", cnt_o, 2);
    step(1, 1, 1, 1);
    chk("pend_rdy2", cfg_rdy, 0);
    chk("pend_cnt2", cnt_o, 3);
    step(1, 0, 0, 0);
    chk("apply_cnt", cnt_o, 0);
    chk("apply_rdy", cfg_rdy, 1);
    for (int j = 1; j <= 10; j++) begin
      step(1, 0, 0, 0);
      chk("div10_cnt", cnt_o, j % 10);
      chk("div10_flag", po_flag, (j == 6) ? 1 : 0);
    end

    // Reset while a div-9 config is pending: immediate defaults.
    run(3);
    step(1, 1, 9, 3);
    chk("pend_b_rdy", cfg_rdy, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_cnt", cnt_o, 0);
    chk("mid_rst_rdy", cfg_rdy, 1);
    chk("mid_rst_flag", po_flag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1, 0, 0, 0);
      chk("post_rst_cnt", cnt_o, k % 4);
      chk("post_rst_flag", po_flag, (k % 4 == 3) ? 1 : 0);
    end

    // div 0 / phase 7 clamps to div 1 / phase 1: tick every second cycle.
    step(1, 1, 0, 7);
    run(3);
    chk("clamp_apply", cnt_o, 0);
    for (int j = 1; j <= 6; j++) begin
      step(1, 0, 0, 0);
      chk("clamp_cnt", cnt_o, j % 2);
      if (j >= 2) chk("clamp_flag", po_flag, (j % 2 == 0) ? 1 : 0);
    end

`ifdef DIV_TICK_SQUARE_EN
    // div_m1=4: square wave high 3 cycles, low 2.
    step(1, 1, 4, 0);
    step(1, 0, 0, 0);
    if (cnt_o != 0) step(1, 0, 0, 0);
    for (int j = 1; j <= 10; j++) begin
      step(1, 0, 0, 0);
      chk("sq5", po_sq, (j % 5 <= 2) ? 1 : 0);
    end
`endif

    // Randomised traffic: enables, config offers with clamping, apply with en low.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 12), $urandom_range(0, 14));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div_tick_gen.md
DIV_TICK_GEN -- requirements
Module: div_tick_gen

Interface
REQ-001 Parameter CNT_W, default 8: width of the divide counter, ratio and phase fields; legal range 2..16.
REQ-002 Parameter RST_DIV_M1, default 3: divide ratio minus one, loaded at reset (divide-by-4).
REQ-003 Parameter RST_PHASE, default 2: pulse phase loaded at reset.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 en  input  1  count enable; when low the counter holds.
REQ-007 cfg_vld  input  1  new configuration offered.
REQ-008 cfg_div_m1  input  CNT_W  requested divide ratio minus one.
REQ-009 cfg_phase  input  CNT_W  requested counter value that triggers the pulse.
REQ-010 cfg_rdy  output  1  block can accept a configuration.
REQ-011 po_flag  output  1  registered one-cycle tick, one per divide period.
REQ-012 po_sq  output  1  registered square wave; present only with DIV_TICK_SQUARE_EN.
REQ-013 cnt_o  output  CNT_W  current counter value.

Function
REQ-014 The counter SHALL count 0..div_m1 when en=1, wrapping to 0 on the edge after reaching div_m1.
REQ-015 po_flag SHALL be 1 for exactly one cycle, on the cycle after the edge that samples cnt==phase with en=1; otherwise 0.
REQ-016 Period of po_flag SHALL be div_m1+1 cycles of continuous en=1.
REQ-017 With en=0, the counter and po_sq SHALL hold and po_flag SHALL be 0; on return to en=1 counting resumes from the held value.
REQ-018 A configuration SHALL be accepted on an edge where cfg_vld=1 and cfg_rdy=1, and captured into shadow registers.
REQ-019 Pending-config FSM: states IDLE (cfg_rdy=1) and PEND (cfg_rdy=0); IDLE->PEND on accept; PEND->IDLE on apply.
REQ-020 Apply SHALL occur on the wrap edge (cnt==div_m1, en=1), or on the next edge if en=0; the counter resets to 0 on apply.
REQ-021 A config accepted on the same edge as a wrap SHALL be applied at the following wrap, not that one.
REQ-022 cfg_div_m1==0 SHALL be clamped to 1; cfg_phase>clamped div_m1 SHALL be clamped to div_m1, both at capture.
REQ-023 cfg_vld while cfg_rdy=0 SHALL be ignored; no queuing beyond one shadow entry.
REQ-024 Counter arithmetic SHALL be unsigned CNT_W bits; no overflow is possible because wrap precedes 2^CNT_W-1+1.

Reset
REQ-025 On rst_n=0: cnt=0, div_m1=RST_DIV_M1, phase=RST_PHASE, FSM=IDLE, cfg_rdy=1, po_flag=0, po_sq=1, all immediately.
REQ-026 Reset asserted mid-period or while PEND SHALL discard the pending config.
REQ-027 Operation SHALL resume on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro DIV_TICK_SQUARE_EN defined: po_sq exists and is registered 1 when next cnt <= div_m1>>1, else 0 (divide-by-4: 1,1,0,0).
REQ-029 Macro undefined: po_sq port and its logic are absent; all other behaviour is unchanged.

Structure
REQ-030 Package div_tick_pkg SHALL hold the FSM state typedef (IDLE, PEND) and the clamp constant MIN_DIV_M1=1.
REQ-031 One sub-module, div_tick_cnt, SHALL contain the counter and wrap detect; the top holds the FSM, shadows and outputs.

Verification
REQ-032 Reset defaults, en=1 for 12 cycles -> po_flag high on cycles 3,7,11 (period 4); cnt_o 0,1,2,3,0...
REQ-033 cfg_div_m1=9, cfg_phase=5 mid-period -> cfg_rdy low until wrap, then period 10, flag 6 cycles after wrap.
REQ-034 cfg_div_m1=0, cfg_phase=7 -> clamped to div 1 / phase 1; po_flag every 2 cycles.
REQ-035 en low for 5 cycles at cnt=2 -> cnt holds at 2, po_flag 0; after en rises flag follows one cycle later.
REQ-036 rst_n pulsed low while PEND with div 9 -> immediate cnt=0, cfg_rdy=1, divide-by-4 restored.
REQ-037 With DIV_TICK_SQUARE_EN, div_m1=4 -> po_sq high 3 cycles, low 2, repeating.
